// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the burst memory controller.
//   WORD_W / DEPTH / ADDR_W : data word width, memory depth, memory address width
//   state_t                 : controller state encoding
//   ctrl_out_t              : bundle of registered control outputs
//   state_outputs()         : control-output values that belong to each state
package mem_bus_ctrl_pkg;

   localparam int WORD_W = 256;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int ADDR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_WAIT  = 3'd1,
      ST_WR_DRIVE = 3'd2,
      ST_RD_ISSUE = 3'd3,
      ST_RD_TURN  = 3'd4,
      ST_RD_HOLD  = 3'd5
   } state_t;

   typedef struct packed {
      logic cmd_ready;
      logic wr_ready;
      logic rd_valid;
      logic busy;
      logic mem_n_enable;
      logic mem_read_write;
      logic drive;
   } ctrl_out_t;

   // The outputs are registered by loading this decode of the *next* state,
   // so every output is a flop yet always agrees with the current state.
   function automatic ctrl_out_t state_outputs(input state_t s);
      ctrl_out_t o;
      o.cmd_ready      = 1'b0;
      o.wr_ready       = 1'b0;
      o.rd_valid       = 1'b0;
      o.busy           = 1'b1;
      o.mem_n_enable   = 1'b1;
      o.mem_read_write = 1'b1;
      o.drive          = 1'b0;
      case (s)
         ST_IDLE: begin
            o.cmd_ready = 1'b1;
            o.busy      = 1'b0;
         end
         ST_WR_WAIT:  o.wr_ready = 1'b1;
         ST_WR_DRIVE: begin
            o.mem_n_enable   = 1'b0;
            o.mem_read_write = 1'b0;
            o.drive          = 1'b1;
         end
         ST_RD_ISSUE: o.mem_n_enable = 1'b0;
         ST_RD_TURN: begin
            o.mem_n_enable   = 1'b0;
            o.mem_read_write = 1'b0;
         end
         ST_RD_HOLD:  o.rd_valid = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Handshake and memory-control signal bundle of the burst memory controller.
//   command : cmd_valid/cmd_ready, cmd_write, cmd_addr, cmd_len
//   write   : wr_data, wr_valid/wr_ready
//   read    : rd_data, rd_valid/rd_ready
//   status  : busy
//   memory  : mem_address, mem_n_enable (active low), mem_read_write
// slave  = controller side, master = producer/consumer side.
interface mem_bus_ctrl_if;
   import mem_bus_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [PTR_W-1:0]  cmd_addr;
   logic [PTR_W-1:0]  cmd_len;
   logic [WORD_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              busy;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_n_enable;
   logic              mem_read_write;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
      output cmd_ready, wr_ready, rd_data, rd_valid, busy,
             mem_address, mem_n_enable, mem_read_write
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready,
      input  cmd_ready, wr_ready, rd_data, rd_valid, busy,
             mem_address, mem_n_enable, mem_read_write
   );

endinterface

// File: rtl/mem_bus_ctrl_burst_counter.sv
// Burst address / remaining-word counter.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : take load_addr / load_len as the new burst
//   step      : advance to the next word (address wraps modulo DEPTH)
//   addr      : address of the current word
//   next_addr : address of the word after the current one
//   last      : current word is the final word of the burst
module mem_bus_ctrl_burst_counter
   import mem_bus_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PTR_W-1:0] load_addr,
   input  logic [PTR_W-1:0] load_len,
   input  logic             step,
   output logic [PTR_W-1:0] addr,
   output logic [PTR_W-1:0] next_addr,
   output logic             last
);

   logic [PTR_W-1:0] addr_reg;
   logic [PTR_W-1:0] remain_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg   <= '0;
         remain_reg <= '0;
      end else if (load) begin
         addr_reg   <= load_addr;
         remain_reg <= load_len;
      end else if (step) begin
         addr_reg   <= next_addr;
         remain_reg <= remain_reg - 1'b1;
      end
   end

   // PTR_W-bit arithmetic gives the modulo-DEPTH wrap for free.
   assign next_addr = addr_reg + 1'b1;
   assign addr      = addr_reg;
   assign last      = (remain_reg == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Burst controller between a command/write/read handshake front end and a
// single-port memory with a shared tristate data bus.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : handshake and memory-control bundle (slave side)
//   data_bus : shared tristate data bus, driven only while writing a word
// Write word: WR_WAIT (handshake) -> WR_DRIVE (memory captures on falling edge).
// Read word : RD_ISSUE -> RD_TURN (memory presents word) -> RD_HOLD (handshake).
module mem_bus_ctrl
   import mem_bus_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   mem_bus_ctrl_if.slave     bus,
   inout  wire  [WORD_W-1:0] data_bus
);

   state_t            state_reg;
   state_t            state_next;
   ctrl_out_t         out_reg;
   logic [ADDR_W-1:0] mem_address_reg;
   logic [WORD_W-1:0] rd_data_reg;
   logic [WORD_W-1:0] wr_word_reg;

   logic              cnt_load;
   logic              cnt_step;
   logic [PTR_W-1:0]  cnt_addr;
   logic [PTR_W-1:0]  cnt_next_addr;
   logic              cnt_last;
   logic [PTR_W-1:0]  issue_addr;

   mem_bus_ctrl_burst_counter u_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .load_addr (bus.cmd_addr),
      .load_len  (bus.cmd_len),
      .step      (cnt_step),
      .addr      (cnt_addr),
      .next_addr (cnt_next_addr),
      .last      (cnt_last)
   );

   always_comb begin
      state_next = state_reg;
      cnt_load   = 1'b0;
      cnt_step   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid && out_reg.cmd_ready) begin
               cnt_load   = 1'b1;
               state_next = bus.cmd_write ? ST_WR_WAIT : ST_RD_ISSUE;
            end
         end
         ST_WR_WAIT: begin
            if (bus.wr_valid) state_next = ST_WR_DRIVE;
         end
         ST_WR_DRIVE: begin
            if (cnt_last) begin
               state_next = ST_IDLE;
            end else begin
               cnt_step   = 1'b1;
               state_next = ST_WR_WAIT;
            end
         end
         ST_RD_ISSUE: state_next = ST_RD_TURN;
         ST_RD_TURN:  state_next = ST_RD_HOLD;
         ST_RD_HOLD: begin
            if (bus.rd_ready) begin
               if (cnt_last) begin
                  state_next = ST_IDLE;
               end else begin
                  cnt_step   = 1'b1;
                  state_next = ST_RD_ISSUE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The counter updates on the same edge that enters the memory cycle, so
   // the registered memory address must be taken from what it is about to hold.
   always_comb begin
      if (cnt_load)      issue_addr = bus.cmd_addr;
      else if (cnt_step) issue_addr = cnt_next_addr;
      else               issue_addr = cnt_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         out_reg         <= state_outputs(ST_IDLE);
         mem_address_reg <= '0;
         rd_data_reg     <= '0;
         wr_word_reg     <= '0;
      end else begin
         state_reg <= state_next;
         out_reg   <= state_outputs(state_next);
         if (state_next == ST_WR_DRIVE || state_next == ST_RD_ISSUE) begin
            mem_address_reg <= {{(ADDR_W-PTR_W){1'b0}}, issue_addr};
         end
         if (state_reg == ST_WR_WAIT && bus.wr_valid) begin
            wr_word_reg <= bus.wr_data;
         end
         // The memory drives its word for the whole turnaround cycle.
         if (state_reg == ST_RD_TURN) begin
            rd_data_reg <= data_bus;
         end
      end
   end

   assign data_bus = out_reg.drive ? wr_word_reg : {WORD_W{1'bz}};

   assign bus.cmd_ready      = out_reg.cmd_ready;
   assign bus.wr_ready       = out_reg.wr_ready;
   assign bus.rd_valid       = out_reg.rd_valid;
   assign bus.busy           = out_reg.busy;
   assign bus.mem_n_enable   = out_reg.mem_n_enable;
   assign bus.mem_read_write = out_reg.mem_read_write;
   assign bus.mem_address    = mem_address_reg;
   assign bus.rd_data        = rd_data_reg;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: a table of bursts driven through the handshakes,
// a behavioural memory on the tristate bus, a per-cycle bus-release monitor,
// and a hand-written reset-during-read sequence.
module tb_mem_bus_ctrl;
   import mem_bus_ctrl_pkg::*;

   logic clk;
   logic rst;
   wire [WORD_W-1:0] data_bus;

   mem_bus_ctrl_if bus ();

   mem_bus_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .data_bus (data_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- memory model ----------------
   // Latches the word on the read-issue edge, presents it during the
   // following enabled cycle, and writes the bus on every enabled falling
   // edge with mem_read_write low.
   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] mem_q;
   logic              rd_pending;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= !bus.mem_n_enable && bus.mem_read_write;
         if (!bus.mem_n_enable && bus.mem_read_write) mem_q <= mem[bus.mem_address[2:0]];
      end
   end

   always @(negedge clk) begin
      if (!bus.mem_n_enable && !bus.mem_read_write) mem[bus.mem_address[2:0]] <= data_bus;
   end

   assign data_bus = (rd_pending && !bus.mem_n_enable) ? mem_q : {WORD_W{1'bz}};

   // Undriven bus reads as Z in a four-state simulator and 0 in a two-state one.
   function automatic bit bus_released();
      return (data_bus == '0) || (^data_bus === 1'bx);
   endfunction

   always @(negedge clk) begin
      if (!rst && (bus.mem_n_enable || bus.mem_read_write)) begin
         n_tests++;
         if (!bus_released()) begin
            n_fail++;
            $display("FAIL bus_release: bus driven while disabled, value %h", data_bus);
         end
      end
   end

   // ---------------- check helpers ----------------
   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [WORD_W-1:0] act,
                             input logic [WORD_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] word_of(input logic [63:0] bytes, input int k);
      int kk;
      kk = k & 7;
      return {(WORD_W/8){bytes[8*kk +: 8]}};
   endfunction

   task automatic check_reset_state(input string tag);
      check_bit({tag, "_busy"},      bus.busy, 1'b0);
      check_bit({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
      check_bit({tag, "_wr_ready"},  bus.wr_ready, 1'b0);
      check_bit({tag, "_rd_valid"},  bus.rd_valid, 1'b0);
      check_word({tag, "_rd_data"},  bus.rd_data, '0);
      check_bit({tag, "_n_enable"},  bus.mem_n_enable, 1'b1);
      check_bit({tag, "_rw"},        bus.mem_read_write, 1'b1);
      check_int({tag, "_addr"},      int'(bus.mem_address), 0);
      check_bit({tag, "_bus_z"},     bus_released(), 1'b1);
   endtask

   // ---------------- burst vectors ----------------
   // bytes: byte of word k at [8k+:8], the word being that byte replicated.
   // cycles: edges from acceptance until busy is seen low (2/word write,
   // 3/word read, plus any consumer stall).
   typedef struct {
      logic       wr;
      logic [2:0] addr;
      logic [2:0] len;
      logic [63:0] bytes;
      int         stall_word;
      int         stall_len;
      bit         poke;
      int         cycles;
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input int idx, input vec_t v);
      int cyc, k_hs, k_mem, stall_left, first_cyc;
      logic [2:0] a;
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_len   = v.len;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      check_bit("accept_busy", bus.busy, 1'b1);
      check_bit("accept_cmd_ready", bus.cmd_ready, 1'b0);
      cyc = 0; k_hs = 0; k_mem = 0; stall_left = v.stall_len; first_cyc = -1;
      while (bus.busy && cyc < 200) begin
         bus.wr_valid = 1'b0;
         bus.rd_ready = 1'b1;
         if (v.poke) begin
            // A conflicting command must be ignored entirely.
            bus.cmd_valid = (cyc % 3 == 1);
            bus.cmd_write = !v.wr;
            bus.cmd_addr  = v.addr + 3'd4;
            check_bit("poke_cmd_ready", bus.cmd_ready, 1'b0);
         end
         if (v.wr && bus.wr_ready) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = word_of(v.bytes, k_hs);
            k_hs++;
         end
         if (v.wr && !bus.mem_n_enable) begin
            if (first_cyc < 0) first_cyc = cyc;
            a = v.addr + 3'(k_mem);
            check_int("wr_addr", int'(bus.mem_address), int'({1'b0, a}));
            check_bit("wr_rw", bus.mem_read_write, 1'b0);
            check_word("wr_bus", data_bus, word_of(v.bytes, k_mem));
            k_mem++;
         end
         if (!v.wr && !bus.mem_n_enable && bus.mem_read_write) begin
            a = v.addr + 3'(k_hs);
            check_int("rd_issue_addr", int'(bus.mem_address), int'({1'b0, a}));
         end
         if (!v.wr && bus.rd_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            check_word("rd_data", bus.rd_data, word_of(v.bytes, k_hs));
            check_bit("rd_hold_mem_off", bus.mem_n_enable, 1'b1);
            if (k_hs == v.stall_word && stall_left > 0) begin
               bus.rd_ready = 1'b0;
               stall_left--;
            end else begin
               k_hs++;
            end
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.cmd_valid = 1'b0;
      bus.wr_valid  = 1'b0;
      check_int("burst_cycles", cyc, v.cycles);
      check_int("burst_words", v.wr ? k_mem : k_hs, int'(v.len) + 1);
      check_int("first_word_cycle", first_cyc, v.wr ? 1 : 2);
      check_bit("end_cmd_ready", bus.cmd_ready, 1'b1);
      if (v.wr) begin
         for (int k = 0; k <= int'(v.len); k++) begin
            a = v.addr + 3'(k);
            check_word("mem_content", mem[a], word_of(v.bytes, k));
         end
      end
      $display("[TB] vec %0d %s addr=%0d len=%0d cycles=%0d", idx,
               v.wr ? "write" : "read", v.addr, v.len, cyc);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      vecs[0] = '{1'b1, 3'd2, 3'd0, 64'hA5,               -1, 0, 1'b0, 2};
      vecs[1] = '{1'b0, 3'd2, 3'd0, 64'hA5,               -1, 0, 1'b0, 3};
      vecs[2] = '{1'b1, 3'd6, 3'd3, 64'hD3D2D1D0,         -1, 0, 1'b1, 8};
      vecs[3] = '{1'b0, 3'd6, 3'd3, 64'hD3D2D1D0,          2, 5, 1'b0, 17};
      vecs[4] = '{1'b1, 3'd5, 3'd0, 64'h55,               -1, 0, 1'b0, 2};
      vecs[5] = '{1'b0, 3'd5, 3'd3, 64'hD2D1D055,         -1, 0, 1'b0, 12};
      vecs[6] = '{1'b1, 3'd0, 3'd7, 64'h1716151413121110, -1, 0, 1'b0, 16};
      vecs[7] = '{1'b0, 3'd3, 3'd7, 64'h1211101716151413, -1, 0, 1'b0, 24};

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_hold");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      check_reset_state("reset_release");

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // Reset in the turnaround cycle of a read burst.
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 3'd2;
      bus.cmd_len   = 3'd2;
      bus.cmd_valid = 1'b1;
      bus.rd_ready  = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      cyc = 0;
      while (!(!bus.mem_n_enable && !bus.mem_read_write) && cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_int("reach_rd_turn", cyc, 1);
      #1 rst = 1'b1;
      #1;
      check_reset_state("reset_in_turn");
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_bit("post_reset_quiet", bus.mem_n_enable, 1'b1);
         check_bit("post_reset_idle", bus.busy, 1'b0);
      end
      $display("[TB] reset during read turnaround");
      run_vec(8, vecs[7]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
